// File: rtl/instr_issue_ctrl.sv
// ---------------------------------------------------------------------------
// instr_issue_ctrl
//
// Buffers instruction words from an upstream source in a small circular
// FIFO and issues them, one per clock, as a registered Instruction word to a
// single-cycle core. A three-state controller (IDLE / RUN / HALT) gates the
// core's reset, inserts NOP bubbles when starved, and stops on HALT_WORD.
//
// Ports
//   CLK          rising-edge clock
//   ResetPC      asynchronous active-high reset
//   start        one-cycle request: IDLE->RUN, or HALT->IDLE
//   in_valid     upstream word valid
//   in_instr     upstream instruction word
//   in_ready     FIFO can accept a word this cycle
//   Instruction  registered word driven to the core
//   issue_valid  Instruction holds a real issued word (not a bubble)
//   core_reset   1 holds the core in reset (state == IDLE)
//   state        00=IDLE, 01=RUN, 10=HALT
//   fifo_count   current FIFO occupancy
//   issue_count  words issued since reset / last IDLE entry (saturating)
// ---------------------------------------------------------------------------
module instr_issue_ctrl #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] NOP_WORD  = 32'h00000013,
  parameter logic [31:0] HALT_WORD = 32'h00100073,
  localparam int unsigned PW       = $clog2(DEPTH),
  localparam int unsigned CW       = PW + 1
) (
  input  logic          CLK,
  input  logic          ResetPC,
  input  logic          start,
  input  logic          in_valid,
  input  logic [31:0]   in_instr,
  output logic          in_ready,
  output logic [31:0]   Instruction,
  output logic          issue_valid,
  output logic          core_reset,
  output logic [1:0]    state,
  output logic [CW-1:0] fifo_count,
  output logic [15:0]   issue_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   instr_q, instr_d;
  logic          valid_q, valid_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   icnt_q, icnt_d;

  logic [31:0]   mem_q [DEPTH];

  logic          push_req;
  logic          mem_we;
  logic          pop_en;
  logic          flush;
  logic [31:0]   head;

  // Ready depends only on registered state, so a pop in the same cycle never
  // makes room early.
  assign in_ready = (cnt_q < CW'(DEPTH)) &&
                    ((state_q == ST_IDLE) || (state_q == ST_RUN));

  assign push_req = in_valid && in_ready;
  // Head is read from the pre-edge array contents, so a word pushed this
  // cycle can never be popped in the same cycle.
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    instr_d = NOP_WORD;
    valid_d = 1'b0;
    icnt_d  = icnt_q;
    pop_en  = 1'b0;
    flush   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (cnt_q != '0) begin
          pop_en = 1'b1;
          if (head == HALT_WORD) begin
            // Stop: drop the queue and any word arriving on this edge.
            flush   = 1'b1;
            state_d = ST_HALT;
          end else begin
            instr_d = head;
            valid_d = 1'b1;
            if (icnt_q != 16'hFFFF) icnt_d = icnt_q + 16'd1;
          end
        end
      end
      ST_HALT: begin
        if (start) begin
          state_d = ST_IDLE;
          icnt_d  = '0;
        end
      end
      default: begin
        // Unused encoding: recover to IDLE with an empty FIFO.
        state_d = ST_IDLE;
        flush   = 1'b1;
      end
    endcase

    mem_we = push_req && !flush;

    if (flush) begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = wr_ptr_q;
      cnt_d    = '0;
    end else begin
      wr_ptr_d = mem_we ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop_en ? rd_ptr_q + PW'(1) : rd_ptr_q;
      cnt_d    = cnt_q + CW'(mem_we) - CW'(pop_en);
    end
  end

  always_ff @(posedge CLK or posedge ResetPC) begin
    if (ResetPC) begin
      state_q  <= ST_IDLE;
      instr_q  <= NOP_WORD;
      valid_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      icnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      icnt_q   <= icnt_d;
    end
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[wr_ptr_q] <= in_instr;
  end

  assign Instruction = instr_q;
  assign issue_valid = valid_q;
  assign core_reset  = (state_q == ST_IDLE);
  assign state       = state_q;
  assign fifo_count  = cnt_q;
  assign issue_count = icnt_q;

endmodule

// File: tb/tb_instr_issue_ctrl.sv
module tb_instr_issue_ctrl;

  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] HALT = 32'h00100073;

  logic        CLK = 1'b0;
  logic        ResetPC = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic        in_ready;
  logic [31:0] Instruction;
  logic        issue_valid;
  logic        core_reset;
  logic [1:0]  state;
  logic [2:0]  fifo_count;
  logic [15:0] issue_count;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b1;
  logic [31:0] exp_q [$];

  instr_issue_ctrl dut (
    .CLK(CLK), .ResetPC(ResetPC), .start(start),
    .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .Instruction(Instruction), .issue_valid(issue_valid),
    .core_reset(core_reset), .state(state),
    .fifo_count(fifo_count), .issue_count(issue_count)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w, input bit expect_issue);
    int n = 0;
    in_valid = 1'b1;
    in_instr = w;
    while (!in_ready && n < 64) begin
      step();
      n++;
    end
    check_val("push_ready", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    if (expect_issue) exp_q.push_back(w);
    $display("push %h", w);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Scoreboard: every issued word must be the next expected word.
  always @(negedge CLK) begin
    if (mon_en && issue_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("issue_unexpected", {31'b0, issue_valid}, 32'd0);
      end else begin
        logic [31:0] w;
        w = exp_q.pop_front();
        check_val("issue_order", Instruction, w);
        $display("issue %h (expected %h)", Instruction, w);
      end
    end
  end

  initial begin
    // Reset state, before any clock edge.
    #2 ResetPC = 1'b1;
    #1;
    check_val("rst_state", {30'b0, state}, 32'd0);
    check_val("rst_core_reset", {31'b0, core_reset}, 32'd1);
    check_val("rst_instr", Instruction, NOP);
    check_val("rst_valid", {31'b0, issue_valid}, 32'd0);
    check_val("rst_fifo", {29'b0, fifo_count}, 32'd0);
    check_val("rst_icnt", {16'b0, issue_count}, 32'd0);
    check_val("rst_ready", {31'b0, in_ready}, 32'd1);
    step();
    ResetPC = 1'b0;

    // Preload in IDLE, then issue in order.
    push_word(32'h002180B3, 1'b1);
    push_word(32'h40310233, 1'b1);
    push_word(32'h003162B3, 1'b1);
    check_val("pre_fifo", {29'b0, fifo_count}, 32'd3);
    check_val("pre_core_reset", {31'b0, core_reset}, 32'd1);
    check_val("pre_valid", {31'b0, issue_valid}, 32'd0);
    pulse_start();
    check_val("run_state", {30'b0, state}, 32'd1);
    check_val("run_core_reset", {31'b0, core_reset}, 32'd0);
    check_val("run_first_valid", {31'b0, issue_valid}, 32'd0);
    step();
    check_val("ord_w0", Instruction, 32'h002180B3);
    check_val("ord_v0", {31'b0, issue_valid}, 32'd1);
    step();
    check_val("ord_w1", Instruction, 32'h40310233);
    step();
    check_val("ord_w2", Instruction, 32'h003162B3);
    check_val("ord_icnt", {16'b0, issue_count}, 32'd3);
    step();
    check_val("bubble_valid", {31'b0, issue_valid}, 32'd0);
    check_val("bubble_instr", Instruction, NOP);
    check_val("bubble_fifo", {29'b0, fifo_count}, 32'd0);

    // Empty FIFO: no bypass.
    push_word(32'h01410493, 1'b1);
    check_val("byp_k_instr", Instruction, NOP);
    check_val("byp_k_valid", {31'b0, issue_valid}, 32'd0);
    step();
    check_val("byp_k1_instr", Instruction, 32'h01410493);
    check_val("byp_k1_valid", {31'b0, issue_valid}, 32'd1);
    step();

    // Halt: first word issued, halt flushes, third dropped.
    push_word(32'h00A00093, 1'b1);
    push_word(HALT, 1'b0);
    push_word(32'h00200113, 1'b0);
    check_val("halt_state", {30'b0, state}, 32'd2);
    check_val("halt_fifo", {29'b0, fifo_count}, 32'd0);
    check_val("halt_icnt", {16'b0, issue_count}, 32'd5);
    check_val("halt_ready", {31'b0, in_ready}, 32'd0);
    check_val("halt_instr", Instruction, NOP);
    check_val("halt_core_reset", {31'b0, core_reset}, 32'd0);
    repeat (3) step();
    check_val("halt_hold", {30'b0, state}, 32'd2);
    pulse_start();
    check_val("h2i_state", {30'b0, state}, 32'd0);
    check_val("h2i_icnt", {16'b0, issue_count}, 32'd0);
    check_val("h2i_fifo", {29'b0, fifo_count}, 32'd0);
    check_val("h2i_ready", {31'b0, in_ready}, 32'd1);

    // Full / backpressure.
    push_word(32'h11111111, 1'b1);
    push_word(32'h22222222, 1'b1);
    push_word(32'h33333333, 1'b1);
    push_word(32'h44444444, 1'b1);
    check_val("full_fifo", {29'b0, fifo_count}, 32'd4);
    check_val("full_ready", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b1;
    in_instr = 32'h55555555;
    exp_q.push_back(32'h55555555);
    repeat (2) step();
    check_val("stall_fifo", {29'b0, fifo_count}, 32'd4);
    check_val("stall_ready", {31'b0, in_ready}, 32'd0);
    pulse_start();
    check_val("full_run_fifo", {29'b0, fifo_count}, 32'd4);
    check_val("full_run_ready", {31'b0, in_ready}, 32'd0);
    step();
    check_val("pop1_fifo", {29'b0, fifo_count}, 32'd3);
    check_val("pop1_ready", {31'b0, in_ready}, 32'd1);
    step();
    check_val("pushpop_fifo", {29'b0, fifo_count}, 32'd3);
    in_valid = 1'b0;
    repeat (6) step();
    check_val("full_icnt", {16'b0, issue_count}, 32'd5);
    check_val("full_drain", {29'b0, fifo_count}, 32'd0);

    // Reset mid-RUN with three words queued plus an in-flight push.
    push_word(HALT, 1'b0);
    step();
    pulse_start();
    push_word(32'hAAAA0001, 1'b0);
    push_word(32'hAAAA0002, 1'b0);
    push_word(32'hAAAA0003, 1'b0);
    pulse_start();
    check_val("mid_fifo", {29'b0, fifo_count}, 32'd3);
    in_valid = 1'b1;
    in_instr = 32'hAAAA0004;
    ResetPC = 1'b1;
    #1;
    check_val("mr_state", {30'b0, state}, 32'd0);
    check_val("mr_core_reset", {31'b0, core_reset}, 32'd1);
    check_val("mr_instr", Instruction, NOP);
    check_val("mr_fifo", {29'b0, fifo_count}, 32'd0);
    check_val("mr_icnt", {16'b0, issue_count}, 32'd0);
    step();
    ResetPC = 1'b0;
    in_valid = 1'b0;
    check_val("mr_inflight", {29'b0, fifo_count}, 32'd0);
    step();
    check_val("mr_idle_state", {30'b0, state}, 32'd0);
    check_val("mr_idle_valid", {31'b0, issue_valid}, 32'd0);
    check_val("mr_idle_fifo", {29'b0, fifo_count}, 32'd0);

    // Saturation.
    mon_en = 1'b0;
    pulse_start();
    in_valid = 1'b1;
    in_instr = 32'h00108093;
    repeat (65600) step();
    in_valid = 1'b0;
    check_val("sat_icnt", {16'b0, issue_count}, 32'h0000FFFF);
    step();
    check_val("sat_hold", {16'b0, issue_count}, 32'h0000FFFF);

    check_val("scoreboard_drain", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_issue_ctrl.md
INSTR_ISSUE_CTRL -- requirements
Module: instr_issue_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning instruction FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter NOP_WORD, default 32'h00000013, meaning bubble instruction (addi x0,x0,0).
REQ-003 SHALL have parameter HALT_WORD, default 32'h00100073, meaning stop instruction (EBREAK).
REQ-004 SHALL use one clock and an asynchronous, active-high reset, with ports named as follows.
REQ-005 CLK  input  1  rising-edge clock.
REQ-006 ResetPC  input  1  asynchronous active-high reset.
REQ-007 start  input  1  one-cycle request: IDLE->RUN, or HALT->IDLE.
REQ-008 in_valid  input  1  upstream instruction word valid.
REQ-009 in_instr  input  32  upstream instruction word.
REQ-010 in_ready  output  1  FIFO can accept a word this cycle.
REQ-011 Instruction  output  32  registered instruction driven to the single-cycle core.
REQ-012 issue_valid  output  1  Instruction holds a real issued word, not a bubble.
REQ-013 core_reset  output  1  drives the core's ResetPC; 1 holds the core in reset.
REQ-014 state  output  2  00=IDLE, 01=RUN, 10=HALT; 11 unused.
REQ-015 fifo_count  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-016 issue_count  output  16  number of words issued since reset or last IDLE entry.

Function
REQ-017 SHALL push in_instr when in_valid && in_ready at a rising edge.
REQ-018 in_ready SHALL be 1 only when fifo_count<DEPTH and state!=HALT; it SHALL NOT be asserted early for a same-cycle pop.
REQ-019 FIFO SHALL be circular with read/write pointers wrapping modulo DEPTH; order SHALL be strictly first-in-first-out.
REQ-020 A pop SHALL see only entries present before the edge; a push into an empty FIFO SHALL NOT bypass to Instruction (minimum latency: push at edge k, issued at edge k+1).
REQ-021 Simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-022 IDLE: core_reset=1, issue_valid=0, Instruction=NOP_WORD; pushes are accepted (preload); start=1 -> RUN at next edge.
REQ-023 RUN: core_reset=0; each edge, if fifo_count>0 pop head; if head!=HALT_WORD, Instruction<=head, issue_valid<=1, issue_count+1.
REQ-024 RUN with empty FIFO: Instruction<=NOP_WORD, issue_valid<=0, issue_count unchanged (bubble).
REQ-025 RUN popping HALT_WORD: Instruction<=NOP_WORD, issue_valid<=0, issue_count unchanged, all remaining entries discarded (fifo_count<=0, pointers equal), state<=HALT; any simultaneous push is dropped.
REQ-026 start in RUN SHALL be ignored.
REQ-027 HALT: core_reset=0, Instruction=NOP_WORD, issue_valid=0, in_ready=0; start=1 -> IDLE at next edge.
REQ-028 Entering IDLE from HALT SHALL clear issue_count to 0 and keep FIFO empty.
REQ-029 issue_count SHALL saturate at 16'hFFFF.
REQ-030 core_reset SHALL be decoded combinationally from the state register only (1 iff state==IDLE).
REQ-031 State 11 SHALL never be entered; if reached it SHALL transition to IDLE at next edge.

Reset
REQ-032 ResetPC=1 SHALL immediately, without waiting for CLK: state=IDLE, core_reset=1, Instruction=NOP_WORD, issue_valid=0, fifo_count=0, pointers=0, issue_count=0, in_ready=1.
REQ-033 ResetPC asserted mid-RUN SHALL discard all FIFO contents and any in-flight push on that edge.
REQ-034 First edge after ResetPC deasserts SHALL behave as IDLE.

Verification
REQ-035 Reset: ResetPC=1 mid-RUN with 3 words queued -> same cycle state=00, core_reset=1, Instruction=0x00000013, fifo_count=0, issue_count=0.
REQ-036 Preload/order: in IDLE push 0x002180B3, 0x40310233, 0x003162B3; pulse start -> core_reset=0, then three consecutive edges issue those words in order with issue_valid=1, issue_count=3, then bubbles.
REQ-037 Full/backpressure: push 5 words in IDLE, DEPTH=4 -> 5th stalls with in_ready=0, fifo_count=4; after start, first pop raises in_ready next cycle and the 5th is accepted, issued 5th.
REQ-038 Empty bypass: RUN with empty FIFO, push 0x01410493 at edge k -> Instruction=NOP, issue_valid=0 after edge k; Instruction=0x01410493, issue_valid=1 after edge k+1.
REQ-039 Halt: queue 0x00A00093, 0x00100073, 0x00200113 in RUN -> first issued, then NOP with state=10, fifo_count=0, issue_count=1, in_ready=0; third never issued; start -> state=00, issue_count=0.
REQ-040 Saturation: force 65536 issues -> issue_count holds 0xFFFF.
